// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : 640x480@60 Hz VGA timing generator for a 50 MHz system clock.
//               A toggling pixel enable divides CLOCK_50 into 25 MHz pixel
//               slots of two clocks each. The horizontal and vertical counters
//               are exported as col/row to a combinational pixel generator.
//               The colour it returns is registered together with blank and
//               syncs, so all DAC-side outputs are mutually aligned one pixel
//               slot after the matching col/row.
// Ports       : CLOCK_50      - 50 MHz system clock
//               reset_L       - asynchronous active-low reset
//               col, row      - current pixel counters (11 bits each)
//               red_in/green_in/blue_in - colour for the current col/row
//               VGA_R/G/B     - registered colour to the DAC (0 when blanked)
//               VGA_HS/VGA_VS - active-low syncs, registered
//               VGA_BLANK_N   - high for visible pixels, registered
//               VGA_SYNC_N    - tied low (sync-on-green unused)
//               VGA_CLK       - 25 MHz pixel clock (the pixel enable)
//               frame_end     - one-clock strobe at the last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset_L,
    output logic [10:0] col,
    output logic [10:0] row,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_end
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] c_H_LAST     = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST     = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] c_VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        r_pix_en;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;

    logic w_h_last;
    logic w_v_last;
    logic w_visible;
    logic w_hs_active;
    logic w_vs_active;

    assign w_h_last    = (r_h_cnt == c_H_LAST);
    assign w_v_last    = (r_v_cnt == c_V_LAST);
    assign w_visible   = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    assign w_hs_active = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
    assign w_vs_active = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);

    // Pixel enable and raster counters. The enable is low on the first edge
    // after reset release, so the first counter advance lands on edge two.
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= 11'd0;
            r_v_cnt  <= 11'd0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_h_cnt <= 11'd0;
                    r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 11'd1;
                end
            end
        end
    end

    // Output stage: colour, blank and syncs are all computed from the same
    // counter values and captured on the same edge, so they cannot skew.
    // The capture edge closes the slot in which the pixel generator settled.
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            r_red     <= 8'd0;
            r_green   <= 8'd0;
            r_blue    <= 8'd0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (r_pix_en) begin
            r_red     <= w_visible ? red_in   : 8'd0;
            r_green   <= w_visible ? green_in : 8'd0;
            r_blue    <= w_visible ? blue_in  : 8'd0;
            r_hs      <= ~w_hs_active;
            r_vs      <= ~w_vs_active;
            r_blank_n <= w_visible;
        end
    end

    assign col         = r_h_cnt;
    assign row         = r_v_cnt;
    assign VGA_R       = r_red;
    assign VGA_G       = r_green;
    assign VGA_B       = r_blue;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    // Low while new data is launched, rising mid-slot when the DAC samples.
    assign VGA_CLK     = r_pix_en;
    assign frame_end   = r_pix_en && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing. A reduced-timing instance
//               exercises whole frames quickly; a default-timing instance is
//               checked over the first lines. Expected outputs come from a
//               slot-arithmetic model of the raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        vclk;
        logic        fe;
    } exp_t;

    // Reduced timing: 35 x 19 slots, 1330 clocks per frame.
    localparam int c_SH = 35;
    localparam int c_SV = 19;
    localparam int c_SFRAME = c_SH * c_SV * 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset_L;
    int          mode;
    int unsigned seed;
    int          errors;
    int          checks;
    int          k;

    logic [10:0] s_col, s_row, d_col, d_row;
    logic [7:0]  s_red, s_green, s_blue, d_red, d_green, d_blue;
    logic [7:0]  s_r, s_g, s_b, d_r, d_g, d_b;
    logic        s_hs, s_vs, s_bn, s_sn, s_vclk, s_fe;
    logic        d_hs, d_vs, d_bn, d_sn, d_vclk, d_fe;
    exp_t        s_obs, d_obs;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_timing #(
        .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .CLOCK_50(CLOCK_50), .reset_L(reset_L), .col(s_col), .row(s_row),
        .red_in(s_red), .green_in(s_green), .blue_in(s_blue),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_CLK(s_vclk), .frame_end(s_fe)
    );

    vga_timing dut_d (
        .CLOCK_50(CLOCK_50), .reset_L(reset_L), .col(d_col), .row(d_row),
        .red_in(d_red), .green_in(d_green), .blue_in(d_blue),
        .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn), .VGA_CLK(d_vclk), .frame_end(d_fe)
    );

    assign s_obs = {s_col, s_row, s_r, s_g, s_b, s_hs, s_vs, s_bn, s_vclk, s_fe};
    assign d_obs = {d_col, d_row, d_r, d_g, d_b, d_hs, d_vs, d_bn, d_vclk, d_fe};

    // Pixel generator stand-in: colour as a function of the pixel position.
    function automatic logic [23:0] pg(input int h, input int v, input int md,
                                       input int unsigned sd);
        logic [7:0] r, g, b;
        case (md)
            0:       begin r = 8'(h); g = 8'(v); b = 8'hA5; end
            1:       begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            default: begin
                r = 8'(h * 7 + v * 13 + int'(sd));
                g = 8'((h ^ (v * 3)) ^ int'(sd >> 8));
                b = 8'(h + v + int'(sd >> 16));
            end
        endcase
        return {r, g, b};
    endfunction

    always_comb begin
        {s_red, s_green, s_blue} = pg(int'(s_col), int'(s_row), mode, seed);
        {d_red, d_green, d_blue} = pg(int'(d_col), int'(d_row), mode, seed);
    end

    // Clock edges since reset release.
    always @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) k <= 0;
        else          k <= k + 1;
    end

    // Raster model: after k edges, n = k/2 pixel slots have completed; the
    // counters show slot n and the output register shows pixel n-1.
    function automatic exp_t model(input int kk, input int hv, input int hf,
                                   input int hw, input int hb, input int vv,
                                   input int vf, input int vw, input int vb,
                                   input int md, input int unsigned sd);
        exp_t        e;
        int          ht, vt, n, p, ph, pv;
        logic        vis;
        logic [23:0] c;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        n  = kk / 2;
        e.col  = 11'(n % ht);
        e.row  = 11'((n / ht) % vt);
        e.vclk = (kk % 2) == 1;
        e.fe   = e.vclk && (n % ht == ht - 1) && ((n / ht) % vt == vt - 1);
        if (n == 0) begin
            e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
            e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        end else begin
            p   = n - 1;
            ph  = p % ht;
            pv  = (p / ht) % vt;
            vis = (ph < hv) && (pv < vv);
            c   = pg(ph, pv, md, sd);
            e.r  = vis ? c[23:16] : 8'd0;
            e.g  = vis ? c[15:8]  : 8'd0;
            e.b  = vis ? c[7:0]   : 8'd0;
            e.hs = !(ph >= hv + hf && ph < hv + hf + hw);
            e.vs = !(pv >= vv + vf && pv < vv + vf + vw);
            e.bn = vis;
        end
        return e;
    endfunction

    function automatic exp_t ms(input int kk);
        return model(kk, 20, 4, 6, 5, 12, 2, 2, 3, mode, seed);
    endfunction

    function automatic exp_t md_(input int kk);
        return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, mode, seed);
    endfunction

    task automatic test_reset;
        exp_t re;
        re = '0;
        re.hs = 1'b1;
        re.vs = 1'b1;
        reset_L = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (s_obs !== re) begin
            errors++;
            $display("FAIL reset_small obs=%h exp=%h", s_obs, re);
        end
        checks++;
        if (d_obs !== re) begin
            errors++;
            $display("FAIL reset_default obs=%h exp=%h", d_obs, re);
        end
        checks++;
        if (s_sn !== 1'b0 || d_sn !== 1'b0) begin
            errors++;
            $display("FAIL sync_n obs=%b/%b exp=0", s_sn, d_sn);
        end
        reset_L = 1'b1;
        @(posedge CLOCK_50); #1;
        checks++;
        if (s_col !== 11'd0 || s_vclk !== 1'b1) begin
            errors++;
            $display("FAIL release_edge1 col=%0d vclk=%b exp col=0 vclk=1", s_col, s_vclk);
        end
        @(posedge CLOCK_50); #1;
        checks++;
        if (s_col !== 11'd1 || d_col !== 11'd1) begin
            errors++;
            $display("FAIL release_edge2 col=%0d/%0d exp=1", s_col, d_col);
        end
    endtask

    task automatic test_line;
        int hs_low, hs_first;
        exp_t e;
        hs_low = 0;
        hs_first = -1;
        while (k < 3 * 1600 + 4) begin
            @(negedge CLOCK_50);
            e = md_(k);
            checks++;
            if (d_obs !== e) begin
                errors++;
                $display("FAIL line k=%0d obs=%h exp=%h", k, d_obs, e);
            end
            if (k <= 1600 && d_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (k == 1600) begin
                checks++;
                if (d_col !== 11'd0 || d_row !== 11'd1) begin
                    errors++;
                    $display("FAIL line_wrap col=%0d row=%0d exp col=0 row=1", d_col, d_row);
                end
            end
        end
        checks++;
        if (hs_low != 192 || hs_first != 1314) begin
            errors++;
            $display("FAIL hs_pulse low=%0d start=%0d exp low=192 start=1314", hs_low, hs_first);
        end
    endtask

    task automatic test_frame;
        int fe_cnt, fe_prev, vs_low;
        logic vs_prev;
        exp_t e;
        fe_cnt = 0;
        fe_prev = -1;
        vs_low = 0;
        vs_prev = s_vs;
        for (int i = 0; i < 2 * c_SFRAME + 10; i++) begin
            @(negedge CLOCK_50);
            e = ms(k);
            checks++;
            if (s_obs !== e) begin
                errors++;
                $display("FAIL frame k=%0d obs=%h exp=%h", k, s_obs, e);
            end
            if (i < c_SFRAME && s_vs === 1'b0) vs_low++;
            if (vs_prev === 1'b1 && s_vs === 1'b0) begin
                checks++;
                if ((k - 982) % c_SFRAME != 0) begin
                    errors++;
                    $display("FAIL vs_start k=%0d exp k=982 mod %0d", k, c_SFRAME);
                end
            end
            vs_prev = s_vs;
            if (s_fe === 1'b1) begin
                fe_cnt++;
                checks++;
                if (s_col !== 11'(c_SH - 1) || s_row !== 11'(c_SV - 1)) begin
                    errors++;
                    $display("FAIL fe_pos col=%0d row=%0d exp col=34 row=18", s_col, s_row);
                end
                if (fe_prev >= 0) begin
                    checks++;
                    if (k - fe_prev != c_SFRAME) begin
                        errors++;
                        $display("FAIL fe_period got=%0d exp=%0d", k - fe_prev, c_SFRAME);
                    end
                end
                fe_prev = k;
            end
        end
        checks++;
        if (fe_cnt != 2 || vs_low != 2 * c_SH * 2) begin
            errors++;
            $display("FAIL frame_counts fe=%0d vs_low=%0d exp fe=2 vs_low=140", fe_cnt, vs_low);
        end
    endtask

    task automatic test_colour;
        int hits, p;
        exp_t e;
        mode = 0;
        repeat (2) @(negedge CLOCK_50);
        hits = 0;
        for (int i = 0; i < c_SFRAME; i++) begin
            @(negedge CLOCK_50);
            e = ms(k);
            checks++;
            if (s_obs !== e) begin
                errors++;
                $display("FAIL colour k=%0d obs=%h exp=%h", k, s_obs, e);
            end
            p = k / 2 - 1;
            if (p % c_SH == 10 && (p / c_SH) % c_SV == 3) begin
                hits++;
                checks++;
                if (s_bn !== 1'b1 || s_r !== 8'd10 || s_g !== 8'd3 || s_b !== 8'hA5) begin
                    errors++;
                    $display("FAIL pixel_10_3 bn=%b rgb=%h%h%h exp bn=1 rgb=0a03a5",
                             s_bn, s_r, s_g, s_b);
                end
            end
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL pixel_10_3_seen got=%0d exp=2", hits);
        end
    endtask

    task automatic test_blank;
        exp_t e;
        mode = 1;
        repeat (2) @(negedge CLOCK_50);
        for (int i = 0; i < c_SFRAME; i++) begin
            @(negedge CLOCK_50);
            e = ms(k);
            checks++;
            if (s_obs !== e) begin
                errors++;
                $display("FAIL blank k=%0d obs=%h exp=%h", k, s_obs, e);
            end
            if (s_bn === 1'b0) begin
                checks++;
                if ({s_r, s_g, s_b} !== 24'd0) begin
                    errors++;
                    $display("FAIL blank_rgb k=%0d rgb=%h exp=000000", k, {s_r, s_g, s_b});
                end
            end
        end
    endtask

    task automatic test_random;
        exp_t e;
        seed = $urandom;
        mode = 2;
        repeat (2) @(negedge CLOCK_50);
        for (int i = 0; i < c_SFRAME; i++) begin
            @(negedge CLOCK_50);
            e = ms(k);
            checks++;
            if (s_obs !== e) begin
                errors++;
                $display("FAIL random k=%0d seed=%h obs=%h exp=%h", k, seed, s_obs, e);
            end
        end
    endtask

    task automatic test_midreset;
        int   budget, vs_first;
        exp_t re, e;
        re = '0;
        re.hs = 1'b1;
        re.vs = 1'b1;
        mode = 0;
        budget = 0;
        @(negedge CLOCK_50);
        while (!(s_col == 11'd12 && s_row == 11'd8) && budget < 3000) begin
            @(negedge CLOCK_50);
            budget++;
        end
        checks++;
        if (budget >= 3000) begin
            errors++;
            $display("FAIL midreset_wait timeout col=%0d row=%0d exp col=12 row=8", s_col, s_row);
        end
        reset_L = 1'b0;
        #1;
        checks++;
        if (s_obs !== re || d_obs !== re) begin
            errors++;
            $display("FAIL midreset_async obs=%h/%h exp=%h", s_obs, d_obs, re);
        end
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_L = 1'b1;
        vs_first = -1;
        for (int i = 0; i < c_SFRAME + 100; i++) begin
            @(negedge CLOCK_50);
            e = ms(k);
            checks++;
            if (s_obs !== e) begin
                errors++;
                $display("FAIL midreset k=%0d obs=%h exp=%h", k, s_obs, e);
            end
            if (vs_first < 0 && s_vs === 1'b0) vs_first = k;
        end
        checks++;
        if (vs_first != 982) begin
            errors++;
            $display("FAIL midreset_vs start=%0d exp=982", vs_first);
        end
    endtask

    initial begin
        reset_L = 1'b0;
        mode    = 0;
        seed    = 0;
        errors  = 0;
        checks  = 0;
        test_reset;
        test_line;
        test_frame;
        test_colour;
        test_blank;
        test_random;
        test_midreset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
